// File: rtl/pulse_timer_pkg.sv
// Shared timer definitions: FSM states and the mode encoding seen on the mode input.
package pulse_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_e;

endpackage

// File: rtl/pulse_timer_if.sv
// Control/status bundle of the pulse timer; master drives controls, slave is the timer.
interface pulse_timer_if #(
  parameter int WIDTH = 8
);
  import pulse_timer_pkg::*;

  logic             en;
  logic             mode;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] load;
  logic             load_we;
  logic             pulse;
  logic [WIDTH-1:0] count;
  logic             busy;

  modport master (
    output en, mode, start, stop, load, load_we,
    input  pulse, count, busy
  );

  modport slave (
    input  en, mode, start, stop, load, load_we,
    output pulse, count, busy
  );

endinterface

// File: rtl/pt_downcounter.sv
// Loadable WIDTH-bit down-counter that saturates at zero and flags the zero value.
module pt_downcounter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;
  logic             zero_s;

  assign zero_s = (count_r == {WIDTH{1'b0}});

  // Counter register: load wins over decrement, decrement stops at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (ld) begin
      count_r <= ld_val;
    end else if (dec && !zero_s) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = zero_s;

endmodule

// File: rtl/pulse_timer.sv
// Programmable periodic / one-shot pulse timer: IDLE/RUN FSM, period register and
// registered expiry pulse around a saturating down-counter.
module pulse_timer #(
  parameter int WIDTH        = 8,
  parameter int RESET_PERIOD = 4
) (
  input  logic           clk,
  input  logic           rst,
  pulse_timer_if.slave   bus
);
  import pulse_timer_pkg::*;

  localparam logic [WIDTH-1:0] RST_PER = WIDTH'(RESET_PERIOD);

  state_e           state_r;
  logic             pulse_r;
  logic             busy_r;
  logic [WIDTH-1:0] per_r;
  logic [WIDTH-1:0] count_s;
  logic             zero_s;
  logic             periodic_s;
  logic             launch_s;
  logic             tick_s;
  logic             expire_s;
  logic             ld_s;
  logic             dec_s;
  logic [WIDTH-1:0] ld_val_s;

  // Event decode shared by the FSM and the counter controls
  always_comb begin
    periodic_s = (mode_e'(bus.mode) == PERIODIC);
    launch_s   = 1'b0;
    tick_s     = 1'b0;
    if (state_r == IDLE) begin
      launch_s = !bus.stop && (bus.start || (periodic_s && bus.en));
    end else begin
      tick_s = !bus.stop && bus.en;
    end
    expire_s = tick_s && zero_s;
    ld_s     = launch_s || (expire_s && periodic_s);
    dec_s    = tick_s && !zero_s;
    // A write on a (re)load edge bypasses the not-yet-updated period register
    if (bus.load_we) begin
      ld_val_s = bus.load;
    end else begin
      ld_val_s = per_r;
    end
  end

  // Period register, writable in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_r <= RST_PER;
    end else if (bus.load_we) begin
      per_r <= bus.load;
    end else begin
      per_r <= per_r;
    end
  end

  // FSM with registered pulse and busy; stop overrides every other event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          pulse_r <= 1'b0;
          if (launch_s) begin
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (expire_s) begin
            pulse_r <= 1'b1;
            if (periodic_s) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= RUN;
            pulse_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  pt_downcounter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld_s),
    .ld_val (ld_val_s),
    .dec    (dec_s),
    .count  (count_s),
    .zero   (zero_s)
  );

  assign bus.pulse = pulse_r;
  assign bus.count = count_s;
  assign bus.busy  = busy_r;

endmodule

// File: doc/pulse_timer.md
PULSE_TIMER -- requirements
Module: pulse_timer

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the period register and down-counter (legal 2..32).
REQ-002 Parameter RESET_PERIOD, default 4, period register value after reset (must fit in WIDTH bits).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  count enable; low freezes the counter.
REQ-006 Port mode  input  1  0 = periodic, 1 = one-shot.
REQ-007 Port start  input  1  single-cycle request to begin counting.
REQ-008 Port stop  input  1  single-cycle request to abort counting.
REQ-009 Port load  input  WIDTH  new period value P.
REQ-010 Port load_we  input  1  write strobe for load.
REQ-011 Port pulse  output  1  registered tick, high for exactly one cycle per expiry.
REQ-012 Port count  output  WIDTH  current down-counter value.
REQ-013 Port busy  output  1  high while the FSM is in RUN.

Function
REQ-014 The block SHALL hold a period register PER, written from load on any rising edge with load_we=1, in any state.
REQ-015 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-016 In IDLE, the FSM SHALL move to RUN on an edge with start=1, or with mode=0 and en=1, provided stop=0; on that edge count <= PER.
REQ-017 If load_we=1 on the IDLE->RUN edge, count SHALL be loaded with load, not the old PER.
REQ-018 In RUN with en=1 and count>0: count <= count-1, pulse <= 0.
REQ-019 In RUN with en=1 and count==0: pulse <= 1; in mode 0, count <= PER (or load if load_we=1 on that edge); in mode 1, the FSM SHALL go to IDLE with count held at 0.
REQ-020 In RUN with en=0, count SHALL hold and pulse SHALL be 0.
REQ-021 Resulting timing: first pulse P+1 edges after the RUN-entry edge; subsequent pulses every P+1 cycles in mode 0.
REQ-022 P=0 SHALL give pulse high on every enabled cycle in mode 0.
REQ-023 A load_we in RUN SHALL NOT alter the in-flight count; the new value takes effect at the next reload.
REQ-024 stop=1 SHALL force IDLE, with pulse <= 0 and count held; stop SHALL win over start, expiry and auto-start on the same edge.
REQ-025 start=1 while in RUN SHALL be ignored (no restart).
REQ-026 A mode change while in RUN SHALL take effect at the next expiry.
REQ-027 In IDLE, pulse SHALL be 0.
REQ-028 The count decrement SHALL never wrap below 0.
REQ-029 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-030 While rst=1, state=IDLE, PER=RESET_PERIOD, count=0, pulse=0 and busy=0, immediately and without waiting for a clock edge.
REQ-031 Reset asserted mid-count SHALL discard the count; after release, behaviour SHALL be identical to power-up.
REQ-032 The first rising edge with rst=0 SHALL be evaluated per REQ-016.

Structure
REQ-033 The state enumeration (IDLE/RUN) and mode encodings (PERIODIC=0, ONESHOT=1) SHALL live in the shared timer package.
REQ-034 The WIDTH-bit loadable down-counter with zero flag SHALL be a sub-module named pt_downcounter; the FSM, PER register and pulse register SHALL reside in pulse_timer.

Verification
REQ-035 Periodic run: reset 60 ns, WIDTH=8, mode=0, en=1, no load_we -> pulse every 5 cycles, first pulse 5 edges after RUN entry, count sequence 4,3,2,1,0,4.
REQ-036 Reload: load=2 with load_we mid-period while count=3 -> current period completes at 5 cycles, then pulses every 3 cycles.
REQ-037 One-shot: mode=1, load=6 with load_we, start pulse -> exactly one pulse 7 edges later, busy drops on the same edge, no further pulses.
REQ-038 Enable gating: en low for 3 cycles at count=2 -> count holds at 2 and the pulse is delayed by exactly 3 cycles.
REQ-039 Priority: stop and start asserted together in IDLE, then stop on the expiry edge in RUN -> remains or goes to IDLE, pulse stays 0.
REQ-040 Async reset: rst asserted between clock edges while count=1 -> outputs clear before the next edge; P=0 afterward (load_we with load=0) -> pulse high on every cycle.
